seven_seg_scanner: RTL



---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/seven_seg_scanner_if.sv | 24 ++
 rtl/seven_seg_decoder.sv | 26 ++
 rtl/seven_seg_scanner.sv | 112 +++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low {g,f,e,d,c,b,a}
// segment patterns, the digit index encoding and the latched-digit payload.
package seven_seg_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    ONES      = 2'd0,
    TENS      = 2'd1,
    HUNDREDS  = 2'd2,
    THOUSANDS = 2'd3
  } digit_sel_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] thousands;
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } digits_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Digit-load input and display-drive output bundle of the scanner.
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic               load;
  logic [DIGIT_W-1:0] thousands;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic [NUM_DIGITS-1:0] anode;
  logic [SEG_W-1:0]   segments;
  logic               dp;
  logic               frame_done;

  modport master (
    output load, thousands, hundreds, tens, ones,
    input  anode, segments, dp, frame_done
  );

  modport slave (
    input  load, thousands, hundreds, tens, ones,
    output anode, segments, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 show a dash.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (digit)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode seven-segment scanner with a latched digit shadow.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  digits_t               shadow;
  logic [CNT_W-1:0]      div_cnt;
  digit_sel_e            sel;

  digit_sel_e            next_sel_c;
  logic [DIGIT_W-1:0]    digit_c;
  logic [NUM_DIGITS-1:0] anode_c;
  logic [SEG_W-1:0]      seg_c;
  logic                  blank_c;
  logic                  slot_end_c;

  assign slot_end_c = (div_cnt == CNT_LAST);

  // Route the selected digit and its anode; precompute the following slot
  always_comb begin
    digit_c    = shadow.ones;
    anode_c    = 4'b1110;
    next_sel_c = TENS;
    case (sel)
      ONES: begin
        digit_c    = shadow.ones;
        anode_c    = 4'b1110;
        next_sel_c = TENS;
      end
      TENS: begin
        digit_c    = shadow.tens;
        anode_c    = 4'b1101;
        next_sel_c = HUNDREDS;
      end
      HUNDREDS: begin
        digit_c    = shadow.hundreds;
        anode_c    = 4'b1011;
        next_sel_c = THOUSANDS;
      end
      THOUSANDS: begin
        digit_c    = shadow.thousands;
        anode_c    = 4'b0111;
        next_sel_c = ONES;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic th_zero_c;
  logic hu_zero_c;
  logic te_zero_c;

  // A digit is blanked only while every digit to its left is also zero
  always_comb begin
    th_zero_c = (shadow.thousands == '0);
    hu_zero_c = (shadow.hundreds == '0);
    te_zero_c = (shadow.tens == '0);
    blank_c   = 1'b0;
    case (sel)
      THOUSANDS: blank_c = th_zero_c;
      HUNDREDS:  blank_c = th_zero_c && hu_zero_c;
      TENS:      blank_c = th_zero_c && hu_zero_c && te_zero_c;
      default:   blank_c = 1'b0;
    endcase
  end
`else
  assign blank_c = 1'b0;
`endif

  seven_seg_decoder u_decoder (
    .digit (digit_c),
    .seg_c (seg_c)
  );

  // Shadow, slot timing and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow         <= '0;
      div_cnt        <= '0;
      sel            <= ONES;
      bus.anode      <= '1;
      bus.segments   <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
      end
      if (slot_end_c) begin
        div_cnt <= '0;
        sel     <= next_sel_c;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      bus.anode      <= blank_c ? '1 : anode_c;
      bus.segments   <= blank_c ? SEG_OFF : seg_c;
      bus.dp         <= 1'b1;
      bus.frame_done <= slot_end_c && (sel == THOUSANDS);
    end
  end

endmodule
